// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32 execute-stage ALU:
//   - ALUControl opcode encodings (3 bits, as produced by the ALU decoder)
//   - default operand / tag widths
//   - alu_entry_t : one buffered ALU result at the default widths
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_TAGW  = 5;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   // 3'b110 and 3'b111 are unassigned and flagged as illegal.

   // Result entry at the default widths. Modules with overridden widths
   // declare a local struct with the same field order.
   typedef struct packed {
      logic [DEF_WIDTH-1:0] result;
      logic                 zero;
      logic                 neg;
      logic                 illegal;
      logic [DEF_TAGW-1:0]  rd;
   } alu_entry_t;

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU: opcode + two operands -> result and flags.
// Shared between the pipelined execute stage and the single-cycle datapath.
//
// Ports:
//   alu_control  in  3      opcode (see alu_pkg)
//   src_a        in  WIDTH  operand A
//   src_b        in  WIDTH  operand B
//   result       out WIDTH  operation result (0 for illegal opcodes)
//   zero         out 1      result == 0
//   neg          out 1      result MSB
//   illegal      out 1      opcode is 110 or 111
// -----------------------------------------------------------------------------
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg,
   output logic             illegal
);

   logic lt;

   assign lt = ($signed(src_a) < $signed(src_b));

   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (alu_control)
         ALU_ADD: result = src_a + src_b;
         ALU_SUB: result = src_a - src_b;
         ALU_AND: result = src_a & src_b;
         ALU_OR:  result = src_a | src_b;
         ALU_XOR: result = src_a ^ src_b;
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
         default: illegal = 1'b1;
      endcase
   end

   assign zero = (result == '0);
   assign neg  = result[WIDTH-1];

endmodule

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
// Execute stage of the pipelined RV32 core. Accepts {opcode, A, B, rd} over a
// valid/ready handshake, computes the result at the input and stores it into a
// 2-entry FIFO. The head entry is presented downstream with valid/ready.
// in_ready depends only on registered state, so a downstream stall never
// creates a combinational path from out_ready to in_ready.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      upstream handshake
//   alu_control, src_a,
//   src_b, rd_in             operation, operands, destination tag
//   flush                    synchronous flush (drops buffer and same-cycle input)
//   out_valid / out_ready    downstream handshake
//   result, zero, neg,
//   rd_out, illegal          head entry fields
// -----------------------------------------------------------------------------
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int TAGW  = DEF_TAGW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [TAGW-1:0]  rd_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg,
   output logic [TAGW-1:0]  rd_out,
   output logic             illegal
);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             zero;
      logic             neg;
      logic             illegal;
      logic [TAGW-1:0]  rd;
   } entry_t;

   entry_t      entry_next;
   entry_t      mem_reg [2];
   entry_t      head_entry;
   logic        head_reg, head_next;
   logic        tail_reg, tail_next;
   logic [1:0]  count_reg, count_next;
   logic        in_ready_reg;
   logic        push, pop;

   // Result is computed combinationally on the input side and captured at
   // the accepting edge.
   alu_core #(.WIDTH(WIDTH)) u_core (
      .alu_control (alu_control),
      .src_a       (src_a),
      .src_b       (src_b),
      .result      (entry_next.result),
      .zero        (entry_next.zero),
      .neg         (entry_next.neg),
      .illegal     (entry_next.illegal)
   );
   assign entry_next.rd = rd_in;

   assign in_ready  = in_ready_reg;
   assign out_valid = (count_reg != 2'd0);
   assign push      = in_valid & in_ready_reg & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_comb begin
      count_next = count_reg;
      head_next  = head_reg;
      tail_next  = tail_reg;
      if (flush) begin
         count_next = 2'd0;
         head_next  = 1'b0;
         tail_next  = 1'b0;
      end else begin
         if (push) tail_next = ~tail_reg;
         if (pop)  head_next = ~head_reg;
         case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
         endcase
      end
   end

   // in_ready is registered from the next count so it reads (count < 2)
   // without any combinational dependency; held low while in reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg    <= 2'd0;
         head_reg     <= 1'b0;
         tail_reg     <= 1'b0;
         in_ready_reg <= 1'b0;
      end else begin
         count_reg    <= count_next;
         head_reg     <= head_next;
         tail_reg     <= tail_next;
         in_ready_reg <= (count_next != 2'd2);
      end
   end

   // Entries are zeroed only by reset so the head outputs read 0 there;
   // flush leaves stale data behind, masked by out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
      end else if (push) begin
         mem_reg[tail_reg] <= entry_next;
      end
   end

   assign head_entry = mem_reg[head_reg];
   assign result     = head_entry.result;
   assign zero       = head_entry.zero;
   assign neg        = head_entry.neg;
   assign illegal    = head_entry.illegal;
   assign rd_out     = head_entry.rd;

endmodule
